// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
// One transaction in flight; data has priority, bounded by a fetch-fairness streak limit.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;     // 1 = data port owns the transaction
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic data_win;
  logic tmo_expired;

  assign data_win    = d_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign tmo_expired = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (!if_req_i) streak_d = '0;
        if (if_req_i || d_req_i) begin
          state_d = S_REQ;
          owner_d = data_win;
          // The streak only counts data wins taken while fetch is waiting.
          if (if_req_i) begin
            if (!data_win) streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_ONE;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i || tmo_expired) state_d = S_IDLE;
        else tmo_d = tmo_q + TMO_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    err_o       = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_REQ: begin
        mem_req_o = 1'b1;
        if (owner_q) begin
          mem_we_o    = d_we_i;
          mem_be_o    = d_be_i;
          mem_addr_o  = d_addr_i;
          mem_wdata_o = d_wdata_i;
          d_gnt_o     = mem_gnt_i;
        end else begin
          mem_be_o   = 4'hF;
          mem_addr_o = if_addr_i;
          if_gnt_o   = mem_gnt_i;
        end
      end
      S_WAIT: begin
        // A timeout completes the transaction with zero data and an error pulse.
        err_o = !mem_rvalid_i && tmo_expired;
        if (owner_q) begin
          d_rvalid_o = mem_rvalid_i || tmo_expired;
          d_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
        end else begin
          if_rvalid_o = mem_rvalid_i || tmo_expired;
          if_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [3:0]  d_be_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o, err_o, busy_o;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one transaction record (owner, granted yet?, cycles waited) plus a streak count.
  bit m_active, m_granted, m_is_data;
  int m_wait, m_streak;

  logic [31:0] s_if_gnt, s_if_rv, s_if_rdata, s_d_gnt, s_d_rv, s_d_rdata;
  logic [31:0] s_mem_req, s_mem_we, s_mem_be, s_mem_addr, s_mem_wdata, s_err, s_busy;

  task automatic cycle();
    logic [31:0] e_if_gnt, e_if_rv, e_if_rdata, e_d_gnt, e_d_rv, e_d_rdata;
    logic [31:0] e_mem_req, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata, e_err, e_busy;
    bit resp, tmo_hit, dw;
    @(negedge clk);
    if (!rst) begin
      m_active = 0; m_granted = 0; m_is_data = 0; m_wait = 0; m_streak = 0;
    end
    e_if_gnt = 0; e_if_rv = 0; e_if_rdata = 0; e_d_gnt = 0; e_d_rv = 0; e_d_rdata = 0;
    e_mem_req = 0; e_mem_we = 0; e_mem_be = 0; e_mem_addr = 0; e_mem_wdata = 0; e_err = 0;
    e_busy = 32'(m_active);
    resp = 0; tmo_hit = 0;
    if (m_active && !m_granted) begin
      e_mem_req = 1;
      if (m_is_data) begin
        e_mem_we = 32'(d_we_i); e_mem_be = 32'(d_be_i); e_mem_addr = d_addr_i;
        e_mem_wdata = d_wdata_i; e_d_gnt = 32'(mem_gnt_i);
      end else begin
        e_mem_be = 32'hF; e_mem_addr = if_addr_i; e_if_gnt = 32'(mem_gnt_i);
      end
    end else if (m_active && m_granted) begin
      tmo_hit = (m_wait == TMO - 1);
      resp = mem_rvalid_i || tmo_hit;
      e_err = 32'(!mem_rvalid_i && tmo_hit);
      if (m_is_data) begin
        e_d_rv = 32'(resp); e_d_rdata = mem_rvalid_i ? mem_rdata_i : 32'h0;
      end else begin
        e_if_rv = 32'(resp); e_if_rdata = mem_rvalid_i ? mem_rdata_i : 32'h0;
      end
    end
    s_if_gnt = 32'(if_gnt_o); s_if_rv = 32'(if_rvalid_o); s_if_rdata = if_rdata_o;
    s_d_gnt = 32'(d_gnt_o); s_d_rv = 32'(d_rvalid_o); s_d_rdata = d_rdata_o;
    s_mem_req = 32'(mem_req_o); s_mem_we = 32'(mem_we_o); s_mem_be = 32'(mem_be_o);
    s_mem_addr = mem_addr_o; s_mem_wdata = mem_wdata_o; s_err = 32'(err_o); s_busy = 32'(busy_o);
    check_val("if_gnt", s_if_gnt, e_if_gnt);
    check_val("if_rvalid", s_if_rv, e_if_rv);
    check_val("if_rdata", s_if_rdata, e_if_rdata);
    check_val("d_gnt", s_d_gnt, e_d_gnt);
    check_val("d_rvalid", s_d_rv, e_d_rv);
    check_val("d_rdata", s_d_rdata, e_d_rdata);
    check_val("mem_req", s_mem_req, e_mem_req);
    check_val("mem_we", s_mem_we, e_mem_we);
    check_val("mem_be", s_mem_be, e_mem_be);
    check_val("mem_addr", s_mem_addr, e_mem_addr);
    check_val("mem_wdata", s_mem_wdata, e_mem_wdata);
    check_val("err", s_err, e_err);
    check_val("busy", s_busy, e_busy);
    if (rst) begin
      if (!m_active) begin
        if (!if_req_i) m_streak = 0;
        if (if_req_i || d_req_i) begin
          dw = d_req_i && !(if_req_i && m_streak == MAXS);
          m_is_data = dw; m_active = 1; m_granted = 0;
          if (if_req_i) m_streak = dw ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
        end
      end else if (!m_granted) begin
        if (mem_gnt_i) begin m_granted = 1; m_wait = 0; end
      end else begin
        if (resp) m_active = 0;
        else m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ng;
    logic [31:0] glog, t_rv, t_rd;
    @(posedge clk); #1;
    cycle(); cycle();
    check_val("rst_busy", s_busy, 32'h0);
    check_val("rst_mem_req", s_mem_req, 32'h0);
    rst = 1'b1;
    cycle();

    // 1: fetch-only load
    if_req_i = 1; if_addr_i = 32'h8000_0000; mem_gnt_i = 1;
    cycle();
    cycle(); check_val("t1_gnt", s_if_gnt, 32'h1); if_req_i = 0;
    cycle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    cycle();
    check_val("t1_rvalid", s_if_rv, 32'h1);
    check_val("t1_rdata", s_if_rdata, 32'h13);
    check_val("t1_d_rvalid", s_d_rv, 32'h0);
    mem_rvalid_i = 0;

    // 2: both request together, data store served first
    if_req_i = 1; if_addr_i = 32'h200;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h100; d_wdata_i = 32'hCAFE_0001;
    cycle();
    cycle();
    check_val("t2_d_gnt", s_d_gnt, 32'h1);
    check_val("t2_we", s_mem_we, 32'h1);
    check_val("t2_be", s_mem_be, 32'h3);
    d_req_i = 0; mem_rvalid_i = 1;
    cycle(); check_val("t2_d_rvalid", s_d_rv, 32'h1);
    mem_rvalid_i = 0;
    cycle();
    cycle(); check_val("t2_if_gnt", s_if_gnt, 32'h1); if_req_i = 0;
    mem_rvalid_i = 1;
    cycle(); mem_rvalid_i = 0;

    // 3: data held high starves fetch until the streak limit
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400; if_req_i = 1; if_addr_i = 32'h500;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    glog = 0; ng = 0;
    for (int i = 0; i < 18; i++) begin
      cycle();
      if (s_d_gnt[0]) begin glog = {glog[30:0], 1'b0}; ng++; end
      if (s_if_gnt[0]) begin glog = {glog[30:0], 1'b1}; ng++; if_req_i = 0; end
    end
    check_val("t3_ngrants", 32'(ng), 32'd6);
    check_val("t3_order", glog, 32'b000010);
    d_req_i = 0; mem_rvalid_i = 0;

    // 4: owner stays fetch while memory stalls and data requests
    if_req_i = 1; if_addr_i = 32'h1000; mem_gnt_i = 0;
    cycle();
    d_req_i = 1; d_addr_i = 32'h300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("t4_addr", s_mem_addr, 32'h1000);
      check_val("t4_d_gnt", s_d_gnt, 32'h0);
    end
    mem_gnt_i = 1;
    cycle(); check_val("t4_if_gnt", s_if_gnt, 32'h1); if_req_i = 0;
    mem_rvalid_i = 1; cycle(); mem_rvalid_i = 0;
    cycle();
    cycle(); check_val("t4_d_gnt_after", s_d_gnt, 32'h1); d_req_i = 0;
    mem_rvalid_i = 1; cycle(); mem_rvalid_i = 0;

    // 5: response timeout
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h40; mem_rdata_i = 32'hFFFF_FFFF;
    cycle();
    cycle(); d_req_i = 0;
    n = 0; t_rv = 0; t_rd = 32'hX;
    for (int i = 0; i < 20; i++) begin
      cycle(); n++;
      if (s_err[0]) begin t_rv = s_d_rv; t_rd = s_d_rdata; break; end
    end
    check_val("t5_wait_cycles", 32'(n), 32'd8);
    check_val("t5_rvalid", t_rv, 32'h1);
    check_val("t5_rdata", t_rd, 32'h0);
    cycle();
    check_val("t5_err_pulse", s_err, 32'h0);
    check_val("t5_busy", s_busy, 32'h0);

    // 6: reset during WAIT, late response dropped
    if_req_i = 1; if_addr_i = 32'h2000;
    cycle();
    cycle(); if_req_i = 0;
    cycle();
    rst = 0;
    cycle(); check_val("t6_busy_rst", s_busy, 32'h0);
    rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    cycle();
    check_val("t6_no_route", s_if_rv, 32'h0);
    check_val("t6_busy", s_busy, 32'h0);
    mem_rvalid_i = 0;

    // Random traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      if (s_if_gnt[0]) if_req_i = 0;
      if (s_d_gnt[0]) d_req_i = 0;
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom;
      end
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_we_i = 1'($urandom_range(0, 1)); d_be_i = 4'($urandom_range(0, 15));
        d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
      rst = ($urandom_range(0, 249) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
